// File: rtl/mul_sequencer.sv
// Sequential signed multiplier with flag generation (MULI/MULR/MULSI/MULSR).
// Latency: start at edge T -> DONE at T+33 (radix-2) or T+17 (radix-4), IDLE one cycle later.
// Backpressure: none; stall holds fetch/decode while busy, and a start seen while busy is dropped.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, mul_type, operand_a,
//   operand_b, destReg           request; sampled only in IDLE
//   flush                        aborts an operation in RUN or DONE
//   busy, stall                  status to the pipeline
//   mul_release, writeToReg      one-cycle result strobes in DONE
//   readRegDest, writeData,
//   flags_out                    result fields; valid in DONE, zero otherwise
//
// Build option: define MUL_RADIX4_EN to retire two multiplier bits per cycle
// (16 RUN cycles). Results and flags are identical in both builds.

module mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mul_type,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  destReg,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        mul_release,
    output logic        writeToReg,
    output logic [3:0]  readRegDest,
    output logic [31:0] writeData,
    output logic [3:0]  flags_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef MUL_RADIX4_EN
    localparam logic [4:0] CNT_LAST = 5'd15;
`else
    localparam logic [4:0] CNT_LAST = 5'd31;
`endif

    state_t      state_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;
    logic        neg_q;
    logic [1:0]  type_q;
    logic [3:0]  dest_q;
    logic        done_q;
    logic [3:0]  rd_q;
    logic [31:0] wdata_q;
    logic [3:0]  flags_q;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] addend;
    logic [63:0] mcand_d;
    logic [31:0] mplier_d;
    logic [63:0] acc_d;
    logic [63:0] prod_d;
    logic [3:0]  flags_d;

    // Magnitudes as unsigned 32-bit values; 0x80000000 negates to itself,
    // which read as unsigned is exactly 2^31.
    assign abs_a = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
    assign abs_b = operand_b[31] ? (~operand_b + 32'd1) : operand_b;

`ifdef MUL_RADIX4_EN
    always_comb begin
        addend = 64'd0;
        case (mplier_q[1:0])
            2'b00:   addend = 64'd0;
            2'b01:   addend = mcand_q;
            2'b10:   addend = mcand_q << 1;
            default: addend = mcand_q + (mcand_q << 1);
        endcase
    end
    assign mcand_d  = mcand_q << 2;
    assign mplier_d = mplier_q >> 2;
`else
    assign addend   = mplier_q[0] ? mcand_q : 64'd0;
    assign mcand_d  = mcand_q << 1;
    assign mplier_d = mplier_q >> 1;
`endif

    assign acc_d = acc_q + addend;

    // acc_d is the complete magnitude product on the final RUN cycle.
    assign prod_d = (neg_q && (acc_d != 64'd0)) ? (~acc_d + 64'd1) : acc_d;

    // V: the 64-bit product does not fit in 32 signed bits.
    assign flags_d = type_q[1] ?
        {prod_d[31], (prod_d[31:0] == 32'd0), 1'b0,
         (prod_d[63:32] != {32{prod_d[31]}})} : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            type_q   <= 2'd0;
            dest_q   <= 4'd0;
            done_q   <= 1'b0;
            rd_q     <= 4'd0;
            wdata_q  <= 32'd0;
            flags_q  <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // flush wins over a same-cycle start
                    if (start && !flush) begin
                        state_q  <= S_RUN;
                        mcand_q  <= {32'd0, abs_a};
                        mplier_q <= abs_b;
                        acc_q    <= 64'd0;
                        cnt_q    <= 5'd0;
                        neg_q    <= operand_a[31] ^ operand_b[31];
                        type_q   <= mul_type;
                        dest_q   <= destReg;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        acc_q   <= 64'd0;
                        cnt_q   <= 5'd0;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_q + 5'd1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            rd_q    <= dest_q;
                            wdata_q <= prod_d[31:0];
                            flags_q <= flags_d;
                        end
                    end
                end
                default: begin
                    // DONE lasts exactly one cycle, flushed or not
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    rd_q    <= 4'd0;
                    wdata_q <= 32'd0;
                    flags_q <= 4'd0;
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign stall       = (start && (state_q == S_IDLE)) || busy;
    // A flush during DONE must suppress the strobes in that same cycle.
    assign mul_release = done_q && !flush;
    assign writeToReg  = done_q && !flush;
    assign readRegDest = rd_q;
    assign writeData   = wdata_q;
    assign flags_out   = flags_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

`ifdef MUL_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mul_type;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  destReg;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        mul_release;
    logic        writeToReg;
    logic [3:0]  readRegDest;
    logic [31:0] writeData;
    logic [3:0]  flags_out;

    int checks = 0;
    int failures = 0;

    // observations captured by run_op
    int          rel_cnt;
    int          rel_n;
    logic [31:0] o_wd;
    logic [3:0]  o_fl;
    logic [3:0]  o_rd;
    logic        o_wr;
    logic        outside_bad;
    logic        stall0;
    logic        busy_at [0:40];
    logic        stall_at[0:40];

    mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mul_type(mul_type),
        .operand_a(operand_a), .operand_b(operand_b), .destReg(destReg),
        .flush(flush), .busy(busy), .stall(stall), .mul_release(mul_release),
        .writeToReg(writeToReg), .readRegDest(readRegDest),
        .writeData(writeData), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    // Reference: exact signed 64-bit product, then the flag rules.
    task automatic model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] wd, output logic [3:0] fl);
        logic signed [63:0] p;
        logic [63:0] pu;
        p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = p;
        wd = pu[31:0];
        fl = t[1] ? {pu[31], (pu[31:0] == 32'd0), 1'b0, (pu[63:32] != {32{pu[31]}})} : 4'b0000;
    endtask

    // Issue one start, then watch 40 cycles. Cycle n is the n-th cycle after
    // the accepting edge. ex_n/fl_n/rs_n (0 = unused) pulse a second start
    // (a=b=9), flush or reset during cycle n.
    task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] d, input int ex_n, input int fl_n, input int rs_n);
        @(negedge clk);
        mul_type = t; operand_a = a; operand_b = b; destReg = d;
        start = 1'b1; flush = 1'b0; rst = 1'b0;
        #1 stall0 = stall;
        @(posedge clk);
        rel_cnt = 0; rel_n = -1; o_wd = 32'hX; o_fl = 4'hX; o_rd = 4'hX; o_wr = 1'b0;
        outside_bad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = (n == ex_n);
            if (n == ex_n) begin
                operand_a = 32'd9; operand_b = 32'd9;
            end
            flush = (n == fl_n);
            rst   = (n == rs_n);
            #1;
            busy_at[n]  = busy;
            stall_at[n] = stall;
            if (mul_release) begin
                rel_cnt++; rel_n = n;
                o_wd = writeData; o_fl = flags_out; o_rd = readRegDest; o_wr = writeToReg;
            end else if (!flush && (writeToReg || writeData != 0 || flags_out != 0 || readRegDest != 0)) begin
                outside_bad = 1'b1;
            end
        end
        start = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; flush = 1'b0;
        operand_a = 32'd5; operand_b = 32'd6; mul_type = 2'b01;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, mul_release, writeToReg} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl busy/rel/wr=%b expected 000", {busy, mul_release, writeToReg});
        end
        checks++;
        if ({readRegDest, writeData, flags_out} !== 40'd0) begin
            failures++;
            $display("FAIL reset_data rd=%h wd=%h fl=%b expected all 0", readRegDest, writeData, flags_out);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, stall} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle busy/stall=%b expected 00", {busy, stall});
        end
    endtask

    task automatic test_directed;
        logic [1:0]  tt [7];
        logic [31:0] aa [7];
        logic [31:0] bb [7];
        logic [31:0] ewd;
        logic [3:0]  efl;
        tt = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
        aa = '{32'd5, 32'd7, 32'h00010000, 32'd0, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        bb = '{32'd6, 32'hFFFFFFFD, 32'h00010000, 32'h12345678, 32'h80000000, 32'd1, 32'hFFFFFFFF};
        for (int i = 0; i < 7; i++) begin
            run_op(tt[i], aa[i], bb[i], 4'(i + 3), 0, 0, 0);
            model(tt[i], aa[i], bb[i], ewd, efl);
            checks++;
            if (rel_cnt !== 1 || rel_n !== LAT) begin
                failures++;
                $display("FAIL dir%0d_release count=%0d cycle=%0d expected 1 at %0d", i, rel_cnt, rel_n, LAT);
            end
            checks++;
            if (o_wd !== ewd || o_fl !== efl) begin
                failures++;
                $display("FAIL dir%0d_result wd=%h fl=%b expected wd=%h fl=%b", i, o_wd, o_fl, ewd, efl);
            end
            checks++;
            if (o_rd !== 4'(i + 3) || o_wr !== 1'b1 || outside_bad !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_fields rd=%h wr=%b outside_bad=%b expected rd=%h wr=1 outside_bad=0",
                         i, o_rd, o_wr, outside_bad, 4'(i + 3));
            end
            checks++;
            if (stall0 !== 1'b1 || busy_at[1] !== 1'b1 || stall_at[3] !== 1'b1 || busy_at[LAT] !== 1'b1
                || busy_at[LAT + 1] !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_busy stall0=%b b1=%b s3=%b bdone=%b bafter=%b expected 1,1,1,1,0",
                         i, stall0, busy_at[1], stall_at[3], busy_at[LAT], busy_at[LAT + 1]);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]  t;
        logic [31:0] a, b;
        logic [3:0]  d;
        logic [31:0] ewd;
        logic [3:0]  efl;
        logic [31:0] corner [5];
        corner = '{32'd0, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        for (int i = 0; i < 20; i++) begin
            t = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 200)) - 100); end
                default: begin a = corner[$urandom_range(0, 4)]; b = $urandom; end
            endcase
            run_op(t, a, b, d, 0, 0, 0);
            model(t, a, b, ewd, efl);
            checks++;
            if (rel_cnt !== 1 || rel_n !== LAT || o_wd !== ewd || o_fl !== efl || o_rd !== d || outside_bad !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d t=%b a=%h b=%h rel=%0d@%0d wd=%h fl=%b rd=%h bad=%b expected 1@%0d wd=%h fl=%b rd=%h",
                         i, t, a, b, rel_cnt, rel_n, o_wd, o_fl, o_rd, outside_bad, LAT, ewd, efl, d);
            end
        end
    endtask

    task automatic test_back_to_back;
        run_op(2'b01, 32'd2, 32'd3, 4'd7, 5, 0, 0);
        checks++;
        if (rel_cnt !== 1 || rel_n !== LAT || o_wd !== 32'd6) begin
            failures++;
            $display("FAIL busy_start rel=%0d@%0d wd=%h expected 1@%0d wd=00000006", rel_cnt, rel_n, o_wd, LAT);
        end
        run_op(2'b11, 32'hFFFFFFFE, 32'd4, 4'd2, 0, 0, 0);
        checks++;
        if (rel_cnt !== 1 || rel_n !== LAT || o_wd !== 32'hFFFFFFF8 || o_fl !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_second rel=%0d@%0d wd=%h fl=%b expected 1@%0d wd=fffffff8 fl=1000",
                     rel_cnt, rel_n, o_wd, o_fl, LAT);
        end
    endtask

    task automatic test_flush;
        run_op(2'b01, 32'd5, 32'd6, 4'd1, 0, 10, 0);
        checks++;
        if (rel_cnt !== 0 || busy_at[10] !== 1'b1 || busy_at[11] !== 1'b0 || outside_bad !== 1'b0) begin
            failures++;
            $display("FAIL flush_run rel=%0d b10=%b b11=%b bad=%b expected 0,1,0,0",
                     rel_cnt, busy_at[10], busy_at[11], outside_bad);
        end
        run_op(2'b01, 32'd5, 32'd6, 4'd1, 0, 0, 0);
        checks++;
        if (rel_cnt !== 1 || rel_n !== LAT || o_wd !== 32'h1E) begin
            failures++;
            $display("FAIL flush_restart rel=%0d@%0d wd=%h expected 1@%0d wd=0000001e", rel_cnt, rel_n, o_wd, LAT);
        end
        run_op(2'b01, 32'd5, 32'd6, 4'd1, 0, LAT, 0);
        checks++;
        if (rel_cnt !== 0 || busy_at[LAT + 1] !== 1'b0) begin
            failures++;
            $display("FAIL flush_done rel=%0d bafter=%b expected 0,0", rel_cnt, busy_at[LAT + 1]);
        end
        run_op(2'b01, 32'd5, 32'd6, 4'd1, 0, LAT - 1, 0);
        checks++;
        if (rel_cnt !== 0 || busy_at[LAT] !== 1'b0) begin
            failures++;
            $display("FAIL flush_last rel=%0d bdone=%b expected 0,0", rel_cnt, busy_at[LAT]);
        end
        // flush and start together in IDLE: start dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; operand_a = 32'd3; operand_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        run_op(2'b11, 32'd5, 32'd6, 4'd9, 0, 0, 20);
        checks++;
        if (rel_cnt !== 0 || busy_at[20] !== 1'b1 || busy_at[21] !== 1'b0 || outside_bad !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid rel=%0d b20=%b b21=%b bad=%b expected 0,1,0,0",
                     rel_cnt, busy_at[20], busy_at[21], outside_bad);
        end
        run_op(2'b01, 32'd5, 32'd6, 4'd4, 0, 0, 0);
        checks++;
        if (rel_cnt !== 1 || rel_n !== LAT || o_wd !== 32'h1E || o_fl !== 4'b0000 || o_rd !== 4'd4) begin
            failures++;
            $display("FAIL reset_recover rel=%0d@%0d wd=%h fl=%b rd=%h expected 1@%0d 0000001e 0000 4",
                     rel_cnt, rel_n, o_wd, o_fl, o_rd, LAT);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        mul_type = 2'b00; operand_a = 32'd0; operand_b = 32'd0; destReg = 4'd0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
